// File: rtl/seg_scan_5dig.sv
// seg_scan_5dig: clamps a binary value to 99999, converts it to BCD with a sequential
// double-dabble engine, and time-multiplexes five active-low 7-segment digits.
module seg_scan_5dig #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [16:0] data_in,
   input  logic        data_valid,
   input  logic [4:0]  point,
   input  logic        disp_en,
   output logic        busy,
   output logic [4:0]  seg_sel,
   output logic [7:0]  seg_led
);

   localparam int unsigned   CW      = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [16:0]   MAX_VAL = 17'd99999;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_COMMIT
   } state_t;

   state_t        state_q;
   logic [16:0]   bin_q;
   logic [19:0]   bcd_q;
   logic [19:0]   bcd_adj;
   logic [4:0]    pt_lat_q;
   logic [4:0]    sh_cnt_q;
   logic          pend_q;
   logic [16:0]   pend_val_q;
   logic [4:0]    pend_pt_q;
   logic          busy_q;
   logic [19:0]   disp_bcd_q;
   logic [4:0]    disp_pt_q;

   logic [CW-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [4:0]    seg_sel_q, seg_sel_d;
   logic [7:0]    seg_led_q, seg_led_d;
   logic [3:0]    nib;
   logic [4:0]    lz;
   logic          blank;

   function automatic logic [16:0] clamp17(input logic [16:0] v);
      return (v > MAX_VAL) ? MAX_VAL : v;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= ST_IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         pt_lat_q   <= '0;
         sh_cnt_q   <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         pend_pt_q  <= '0;
         busy_q     <= 1'b0;
         disp_bcd_q <= '0;
         disp_pt_q  <= '0;
      end else begin
         // Any strobe outside IDLE lands in the pending slot; COMMIT below consumes it.
         if (state_q != ST_IDLE && data_valid) begin
            pend_q     <= 1'b1;
            pend_val_q <= clamp17(data_in);
            pend_pt_q  <= point;
         end
         case (state_q)
            ST_IDLE: begin
               if (data_valid) begin
                  bin_q    <= clamp17(data_in);
                  pt_lat_q <= point;
                  busy_q   <= 1'b1;
                  state_q  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               bcd_q    <= '0;
               sh_cnt_q <= '0;
               state_q  <= ST_SHIFT;
            end
            ST_SHIFT: begin
               bcd_q    <= {bcd_adj[18:0], bin_q[16]};
               bin_q    <= {bin_q[15:0], 1'b0};
               sh_cnt_q <= sh_cnt_q + 5'd1;
               if (sh_cnt_q == 5'd16) state_q <= ST_COMMIT;
            end
            ST_COMMIT: begin
               disp_bcd_q <= bcd_q;
               disp_pt_q  <= pt_lat_q;
               pend_q     <= 1'b0;
               if (data_valid) begin
                  bin_q    <= clamp17(data_in);
                  pt_lat_q <= point;
                  state_q  <= ST_LOAD;
               end else if (pend_q) begin
                  bin_q    <= pend_val_q;
                  pt_lat_q <= pend_pt_q;
                  state_q  <= ST_LOAD;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Outputs are computed from the post-edge index so seg_sel and seg_led switch together.
   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (scan_cnt_q == CNT_MAX) begin
         scan_cnt_d = '0;
         idx_d      = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end
      lz[4] = (disp_bcd_q[19:16] == 4'd0);
      lz[3] = lz[4] && (disp_bcd_q[15:12] == 4'd0);
      lz[2] = lz[3] && (disp_bcd_q[11:8] == 4'd0);
      lz[1] = lz[2] && (disp_bcd_q[7:4] == 4'd0);
      lz[0] = lz[1] && (disp_bcd_q[3:0] == 4'd0);
      case (idx_d)
         3'd1:    nib = disp_bcd_q[7:4];
         3'd2:    nib = disp_bcd_q[11:8];
         3'd3:    nib = disp_bcd_q[15:12];
         3'd4:    nib = disp_bcd_q[19:16];
         default: nib = disp_bcd_q[3:0];
      endcase
      blank     = BLANK_LZ && (idx_d != 3'd0) && lz[idx_d];
      seg_sel_d = '1;
      seg_led_d = '1;
      if (disp_en) begin
         seg_sel_d = ~(5'b00001 << idx_d);
         seg_led_d = {~disp_pt_q[idx_d], blank ? 7'h7F : seg7(nib)};
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
         seg_sel_q  <= '1;
         seg_led_q  <= '1;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         seg_sel_q  <= seg_sel_d;
         seg_led_q  <= seg_led_d;
      end
   end

   assign busy    = busy_q;
   assign seg_sel = seg_sel_q;
   assign seg_led = seg_led_q;

endmodule

// File: tb/tb_seg_scan_5dig.sv
// Self-checking bench for seg_scan_5dig: expected digits come from integer arithmetic on the
// displayed value; scan timing is predicted from the scan period.
module tb_seg_scan_5dig;

   localparam int unsigned SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [16:0] data_in;
   logic        data_valid;
   logic [4:0]  point;
   logic        disp_en;
   logic        busy;
   logic [4:0]  seg_sel;
   logic [7:0]  seg_led;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   int unsigned cur_val = 0;
   logic [4:0]  cur_pt  = '0;

   logic [7:0]  seen [5];
   logic [4:0]  seen_mask;
   int unsigned bad_sel;
   bit          timed_out;

   seg_scan_5dig #(
      .SCAN_DIV(SCAN_DIV),
      .BLANK_LZ(1'b1)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .data_in   (data_in),
      .data_valid(data_valid),
      .point     (point),
      .disp_en   (disp_en),
      .busy      (busy),
      .seg_sel   (seg_sel),
      .seg_led   (seg_led)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] seg_code(int unsigned d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;  4: return 8'h99;
         5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;  8: return 8'h80;  9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // Reference: decimal digit of the clamped value, leading-zero blanking, dp from point.
   function automatic logic [7:0] exp_led(int unsigned value, logic [4:0] pt, int unsigned idx);
      int unsigned v;
      int unsigned p;
      logic [7:0]  s;
      v = (value > 99999) ? 99999 : value;
      p = 1;
      for (int unsigned k = 0; k < idx; k++) p = p * 10;
      s    = ((idx != 0) && (v < p)) ? 8'hFF : seg_code((v / p) % 10);
      s[7] = ~pt[idx];
      return s;
   endfunction

   function automatic int sel_to_idx(logic [4:0] s);
      case (s)
         5'b11110: return 0;
         5'b11101: return 1;
         5'b11011: return 2;
         5'b10111: return 3;
         5'b01111: return 4;
         default:  return -1;
      endcase
   endfunction

   task automatic pulse(int unsigned v, logic [4:0] pt);
      @(negedge clk);
      data_in    = v[16:0];
      point      = pt;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit to);
      int unsigned guard;
      guard = 0;
      while (busy !== 1'b0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      to = (guard >= 200);
      repeat (2) @(negedge clk);
   endtask

   task automatic capture();
      int idx;
      seen_mask = '0;
      bad_sel   = 0;
      for (int unsigned c = 0; c < 5 * SCAN_DIV + 2; c++) begin
         @(negedge clk);
         idx = sel_to_idx(seg_sel);
         if (idx < 0) bad_sel++;
         else begin
            seen[idx]      = seg_led;
            seen_mask[idx] = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; disp_en = 1'b1; data_valid = 1'b0; data_in = '0; point = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
      vectors++;
      if (seg_sel !== 5'b11111) begin miscompares++; $display("FAIL reset_sel got %b exp 11111", seg_sel); end
      vectors++;
      if (seg_led !== 8'hFF) begin miscompares++; $display("FAIL reset_led got %h exp FF", seg_led); end
      rst_n = 1'b1;
      capture();
      vectors++;
      if (bad_sel != 0) begin miscompares++; $display("FAIL reset_scan_sel bad=%0d exp 0", bad_sel); end
      for (int unsigned i = 0; i < 5; i++) begin
         vectors++;
         if (seen_mask[i] !== 1'b1 || seen[i] !== exp_led(0, 5'b0, i)) begin
            miscompares++;
            $display("FAIL reset_digit%0d got %h exp %h", i, seen[i], exp_led(0, 5'b0, i));
         end
      end
   endtask

   task automatic test_convert_12345();
      int unsigned cnt;
      int unsigned guard;
      pulse(12345, 5'b0);
      cnt = 0; guard = 0;
      while (busy === 1'b1 && guard < 100) begin
         cnt++; guard++;
         @(negedge clk);
      end
      vectors++;
      if (cnt != 19) begin miscompares++; $display("FAIL busy_len got %0d exp 19", cnt); end
      cur_val = 12345; cur_pt = '0;
      repeat (2) @(negedge clk);
      capture();
      for (int unsigned i = 0; i < 5; i++) begin
         vectors++;
         if (seen_mask[i] !== 1'b1 || seen[i] !== exp_led(cur_val, cur_pt, i)) begin
            miscompares++;
            $display("FAIL d12345_digit%0d got %h exp %h", i, seen[i], exp_led(cur_val, cur_pt, i));
         end
      end
   endtask

   task automatic test_clamp_and_point();
      int unsigned vals [2] = '{120000, 7};
      logic [4:0]  pts  [2] = '{5'b00000, 5'b00010};
      for (int unsigned t = 0; t < 2; t++) begin
         pulse(vals[t], pts[t]);
         wait_idle(timed_out);
         vectors++;
         if (timed_out) begin miscompares++; $display("FAIL clamp_timeout busy got 1 exp 0"); end
         cur_val = vals[t]; cur_pt = pts[t];
         capture();
         for (int unsigned i = 0; i < 5; i++) begin
            vectors++;
            if (seen_mask[i] !== 1'b1 || seen[i] !== exp_led(cur_val, cur_pt, i)) begin
               miscompares++;
               $display("FAIL clamp_pt_v%0d_digit%0d got %h exp %h", cur_val, i, seen[i],
                        exp_led(cur_val, cur_pt, i));
            end
         end
      end
   endtask

   task automatic test_random();
      int unsigned v;
      logic [4:0]  pt;
      for (int unsigned t = 0; t < 10; t++) begin
         case (t)
            0: begin v = 0;      pt = 5'b11111; end
            1: begin v = 99999;  pt = 5'b00000; end
            2: begin v = 100000; pt = 5'b10101; end
            3: begin v = 131071; pt = 5'b00000; end
            4: begin v = 10;     pt = 5'b00000; end
            default: begin v = $urandom_range(131071, 0); pt = 5'($urandom); end
         endcase
         pulse(v, pt);
         wait_idle(timed_out);
         vectors++;
         if (timed_out) begin miscompares++; $display("FAIL rand_timeout v=%0d busy got 1 exp 0", v); end
         cur_val = v; cur_pt = pt;
         capture();
         for (int unsigned i = 0; i < 5; i++) begin
            vectors++;
            if (seen_mask[i] !== 1'b1 || seen[i] !== exp_led(cur_val, cur_pt, i)) begin
               miscompares++;
               $display("FAIL rand_v%0d_digit%0d got %h exp %h", v, i, seen[i], exp_led(cur_val, cur_pt, i));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned first_low;
      int          idx;
      pulse(100, 5'b0);
      first_low = 999;
      for (int unsigned k = 0; k < 46; k++) begin
         if (busy !== 1'b1 && first_low == 999) first_low = k;
         if (k >= 21 && k <= 36) begin
            idx = sel_to_idx(seg_sel);
            if (idx >= 0) begin
               vectors++;
               if (seg_led !== exp_led(100, 5'b0, idx)) begin
                  miscompares++;
                  $display("FAIL b2b_first_value k=%0d digit%0d got %h exp %h", k, idx, seg_led,
                           exp_led(100, 5'b0, idx));
               end
            end
         end
         case (k)
            4: begin data_in = 17'd250; data_valid = 1'b1; end
            8: begin data_in = 17'd42;  data_valid = 1'b1; end
            5, 9: data_valid = 1'b0;
            default: ;
         endcase
         @(negedge clk);
      end
      vectors++;
      if (first_low != 38) begin miscompares++; $display("FAIL b2b_busy_len got %0d exp 38", first_low); end
      cur_val = 42; cur_pt = '0;
      capture();
      for (int unsigned i = 0; i < 5; i++) begin
         vectors++;
         if (seen_mask[i] !== 1'b1 || seen[i] !== exp_led(cur_val, cur_pt, i)) begin
            miscompares++;
            $display("FAIL b2b_last_digit%0d got %h exp %h", i, seen[i], exp_led(cur_val, cur_pt, i));
         end
      end
   endtask

   task automatic test_reset_mid_conv();
      int idx;
      pulse(54321, 5'b00100);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || seg_sel !== 5'b11111 || seg_led !== 8'hFF) begin
         miscompares++;
         $display("FAIL midrst_outputs got busy=%b sel=%b led=%h exp 0/11111/FF", busy, seg_sel, seg_led);
      end
      rst_n   = 1'b1;
      cur_val = 0; cur_pt = '0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b exp 0", busy); end
      pulse(8, 5'b0);
      for (int unsigned k = 0; k < 18; k++) begin
         idx = sel_to_idx(seg_sel);
         if (idx >= 0) begin
            vectors++;
            if (seg_led !== exp_led(0, 5'b0, idx)) begin
               miscompares++;
               $display("FAIL midrst_cleared k=%0d digit%0d got %h exp %h", k, idx, seg_led,
                        exp_led(0, 5'b0, idx));
            end
         end
         @(negedge clk);
      end
      wait_idle(timed_out);
      vectors++;
      if (timed_out) begin miscompares++; $display("FAIL midrst_timeout busy got 1 exp 0"); end
      cur_val = 8; cur_pt = '0;
      capture();
      for (int unsigned i = 0; i < 5; i++) begin
         vectors++;
         if (seen_mask[i] !== 1'b1 || seen[i] !== exp_led(cur_val, cur_pt, i)) begin
            miscompares++;
            $display("FAIL midrst_digit%0d got %h exp %h", i, seen[i], exp_led(cur_val, cur_pt, i));
         end
      end
   endtask

   task automatic test_disp_en();
      logic [4:0]  prev;
      int unsigned guard;
      int          i0;
      int unsigned exp_idx;
      logic [4:0]  exp_sel;
      @(negedge clk);
      prev = seg_sel; guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (seg_sel === prev && guard < 40);
      i0 = sel_to_idx(seg_sel);
      vectors++;
      if (i0 < 0) begin miscompares++; $display("FAIL dis_slot_edge sel got %b exp one-hot-low", seg_sel); i0 = 0; end
      disp_en = 1'b0;
      for (int unsigned j = 1; j <= 10; j++) begin
         @(negedge clk);
         vectors++;
         if (seg_sel !== 5'b11111 || seg_led !== 8'hFF) begin
            miscompares++;
            $display("FAIL dis_off cyc%0d got sel=%b led=%h exp 11111/FF", j, seg_sel, seg_led);
         end
      end
      disp_en = 1'b1;
      @(negedge clk);
      exp_idx = (i0 + 11 / SCAN_DIV) % 5;
      exp_sel = ~(5'b00001 << exp_idx);
      vectors++;
      if (seg_sel !== exp_sel) begin
         miscompares++;
         $display("FAIL dis_resume_sel got %b exp %b", seg_sel, exp_sel);
      end
      vectors++;
      if (seg_led !== exp_led(cur_val, cur_pt, exp_idx)) begin
         miscompares++;
         $display("FAIL dis_resume_led got %h exp %h", seg_led, exp_led(cur_val, cur_pt, exp_idx));
      end
   endtask

   initial begin
      test_reset();
      test_convert_12345();
      test_clamp_and_point();
      test_random();
      test_back_to_back();
      test_reset_mid_conv();
      test_disp_en();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
